// File: rtl/passcode_checker.sv
// Door-lock passcode state machine: collects BCD key digits, checks them on ENTER,
// drives a timed unlock, counts failures into a timed lockout, and supports code change.
module passcode_checker #(
    parameter int                      CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                      UNLOCK_CYCLES  = 50_000_000,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] digit_pulse,
    input  logic       enter_pulse,
    input  logic       clear_pulse,
    input  logic       set_pulse,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] entry_count,
    output logic [1:0] fail_count
);

    localparam int W       = 4 * CODE_LEN;
    localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0]    FULL        = 3'(CODE_LEN);
    localparam logic [2:0]    FAIL_LIMIT  = 3'(MAX_FAILS);
    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_SET,
        S_LOCKOUT
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  buffer, buffer_next;
    logic [W-1:0]  stored, stored_next;
    logic [2:0]    count_next;
    logic [1:0]    fail_next;
    logic [TW-1:0] timer, timer_next;
    logic [3:0]    digit_value;
    logic          digit_event;

    // Only a one-hot digit_pulse counts as a key; the index becomes the BCD value.
    always_comb begin
        digit_value = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (digit_pulse[k]) digit_value = 4'(k);
        end
        digit_event = (digit_pulse != 10'd0) &&
                      ((digit_pulse & (digit_pulse - 10'd1)) == 10'd0);
    end

    always_comb begin
        state_next  = state;
        buffer_next = buffer;
        stored_next = stored;
        count_next  = entry_count;
        fail_next   = fail_count;
        timer_next  = timer;

        case (state)
            S_LOCKED, S_SET: begin
                if (clear_pulse) begin
                    buffer_next = '0;
                    count_next  = 3'd0;
                end else if (enter_pulse) begin
                    buffer_next = '0;
                    count_next  = 3'd0;
                    if (state == S_SET) begin
                        if (entry_count == FULL) stored_next = buffer;
                        state_next = S_LOCKED;
                    end else if (entry_count == FULL && buffer == stored) begin
                        state_next = S_UNLOCKED;
                        timer_next = UNLOCK_LOAD;
                        fail_next  = 2'd0;
                    end else if (({1'b0, fail_count} + 3'd1) >= FAIL_LIMIT) begin
                        state_next = S_LOCKOUT;
                        timer_next = LOCK_LOAD;
                        fail_next  = FAIL_LIMIT[1:0];
                    end else begin
                        fail_next = fail_count + 2'd1;
                    end
                end else if (digit_event && entry_count != FULL) begin
                    buffer_next = (buffer << 4) | W'(digit_value);
                    count_next  = entry_count + 3'd1;
                end
            end
            S_UNLOCKED: begin
                if (set_pulse) begin
                    state_next  = S_SET;
                    buffer_next = '0;
                    count_next  = 3'd0;
                    timer_next  = '0;
                end else if (enter_pulse || timer == '0) begin
                    state_next = S_LOCKED;
                    timer_next = '0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_next  = S_LOCKED;
                    fail_next   = 2'd0;
                    buffer_next = '0;
                    count_next  = 3'd0;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: state_next = S_LOCKED;
        endcase
    end

    // unlocked/alarm are registered decodes of the next state, so they track it with no comb path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_LOCKED;
            buffer      <= '0;
            stored      <= DEFAULT_CODE;
            entry_count <= 3'd0;
            fail_count  <= 2'd0;
            timer       <= '0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_next;
            buffer      <= buffer_next;
            stored      <= stored_next;
            entry_count <= count_next;
            fail_count  <= fail_next;
            timer       <= timer_next;
            unlocked    <= (state_next == S_UNLOCKED);
            alarm       <= (state_next == S_LOCKOUT);
        end
    end

endmodule
